// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the processor load/store port. Accepts one
//   request at a time, waits WAIT_CYCLES wait states, performs a byte,
//   halfword or word access on internal storage and returns the result over
//   a second valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    responder can accept a request
//   req_write    1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   req_size     00 byte, 01 halfword, 10 word, 11 reserved
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   resp_valid   response present
//   resp_ready   requester accepts the response
//   resp_rdata   extended load result, 0 for stores and errors
//   resp_error   misaligned, out-of-range or reserved-size request
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  logic              errQ;

  logic              reqWrite;
  logic              reqUnsigned;
  logic [31:0]       reqAddr;
  logic [31:0]       reqWdata;
  logic [1:0]        reqSize;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdWord;

  logic              accessErr;
  logic [3:0]        wrMask;
  logic [31:0]       wrData;
  logic [AW-1:0]     memIdx;

  // Lane selection and sign/zero extension of a raw storage word.
  function automatic logic [31:0] loadExtend(input logic [31:0] w,
                                             input logic [1:0]  sz,
                                             input logic [1:0]  lane,
                                             input logic        uns);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   loadExtend = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   loadExtend = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: loadExtend = w;
    endcase
  endfunction

  assign memIdx = reqAddr[2 +: AW];

  // Error check on the latched request; any index bit above the storage
  // range makes the access out of range, whatever the size.
  always_comb begin
    accessErr = 1'b0;
    case (reqSize)
      2'b00:   accessErr = 1'b0;
      2'b01:   accessErr = reqAddr[0];
      2'b10:   accessErr = (reqAddr[1:0] != 2'b00);
      default: accessErr = 1'b1;
    endcase
    if (reqAddr[31:2+AW] != '0) accessErr = 1'b1;
  end

  // Store data is replicated across lanes so the byte mask alone picks lanes.
  always_comb begin
    wrMask = 4'b1111;
    wrData = reqWdata;
    case (reqSize)
      2'b00: begin
        wrMask = 4'b0001 << reqAddr[1:0];
        wrData = {4{reqWdata[7:0]}};
      end
      2'b01: begin
        wrMask = reqAddr[1] ? 4'b1100 : 4'b0011;
        wrData = {2{reqWdata[15:0]}};
      end
      default: begin
        wrMask = 4'b1111;
        wrData = reqWdata;
      end
    endcase
  end

  // Request capture: only the IDLE acceptance cycle samples the inputs.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      reqWrite    <= req_write;
      reqUnsigned <= req_unsigned;
      reqAddr     <= req_addr;
      reqWdata    <= req_wdata;
      reqSize     <= req_size;
    end
  end

  // Storage: written and read on the ACCESS edge. The read is registered,
  // so the response word is formed from rdWord on the following edge.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      if (reqWrite && !accessErr) begin
        if (wrMask[0]) mem[memIdx][7:0]   <= wrData[7:0];
        if (wrMask[1]) mem[memIdx][15:8]  <= wrData[15:8];
        if (wrMask[2]) mem[memIdx][23:16] <= wrData[23:16];
        if (wrMask[3]) mem[memIdx][31:24] <= wrData[31:24];
      end
      rdWord <= mem[memIdx];
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      waitCnt    <= '0;
      errQ       <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state   <= WAIT;
              waitCnt <= CNT_W'(WAIT_CYCLES - 1);
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (waitCnt == '0) state <= ACCESS;
          else               waitCnt <= waitCnt - 1'b1;
        end
        ACCESS: begin
          errQ  <= accessErr;
          state <= RESP;
        end
        RESP: begin
          // First RESP cycle builds the response from the registered read.
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_error <= errQ;
            resp_rdata <= (errQ || reqWrite) ? '0 :
                          loadExtend(rdWord, reqSize, reqAddr[1:0], reqUnsigned);
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;

  logic        zValid, zReady, zWrite, zUns, zRespValid, zRespReady, zRespErr;
  logic [31:0] zAddr, zWdata, zRdata;
  logic [1:0]  zSize;

  int nChecks = 0;
  int nFail   = 0;
  logic [32:0] expQ[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  dmem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(zValid), .req_ready(zReady), .req_write(zWrite),
    .req_addr(zAddr), .req_wdata(zWdata), .req_size(zSize),
    .req_unsigned(zUns),
    .resp_valid(zRespValid), .resp_ready(zRespReady),
    .resp_rdata(zRdata), .resp_error(zRespErr)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transaction on the main DUT with resp_ready held high.
  task automatic runReq(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] sz,
                        input logic uns, input logic [31:0] expData,
                        input logic expErr, input string name);
    int lat;
    bit got;
    logic [32:0] exp;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd; req_size = sz; req_unsigned = uns;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_ready) got = 1;
      else @(negedge clk);
    end
    nChecks++;
    if (!got) begin
      nFail++;
      $display("FAIL %s accept: req_ready stayed 0, required 1", name);
      req_valid = 1'b0;
      return;
    end
    expQ.push_back({expErr, expData});
    @(posedge clk); #1;
    // Scramble the request inputs: they must be ignored after acceptance.
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom;
    req_wdata = $urandom; req_size = ~sz; req_unsigned = ~uns;
    got = 0; lat = 0;
    while (!got && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (resp_valid) got = 1;
    end
    exp = expQ.pop_front();
    nChecks++;
    if (!got) begin
      nFail++;
      $display("FAIL %s response: resp_valid never rose, required 1", name);
      return;
    end
    nChecks++;
    if (lat != WAITC + 2) begin
      nFail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, WAITC + 2);
    end
    nChecks++;
    if ({resp_error, resp_rdata} !== exp || req_ready !== 1'b0) begin
      nFail++;
      $display("FAIL %s data: got err=%0b rdata=%h req_ready=%0b, required err=%0b rdata=%h req_ready=0",
               name, resp_error, resp_rdata, req_ready, exp[32], exp[31:0]);
    end
    @(posedge clk); #1;
    nChecks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      nFail++;
      $display("FAIL %s release: got valid=%0b ready=%0b rdata=%h err=%0b, required 0 1 0 0",
               name, resp_valid, req_ready, resp_rdata, resp_error);
    end
  endtask

  task automatic test_reset();
    nChecks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state: got ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_error);
    end
    nChecks++;
    if (zReady !== 1'b1 || zRespValid !== 1'b0 || zRdata !== 32'h0 || zRespErr !== 1'b0) begin
      nFail++;
      $display("FAIL reset_state_w0: got ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
               zReady, zRespValid, zRdata, zRespErr);
    end
  endtask

  task automatic test_word();
    runReq(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, "store_word");
    runReq(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, "load_word");
  endtask

  task automatic test_half();
    runReq(1, 32'h20, 32'h12348001, 2'b10, 0, 32'h0, 0, "store_w20");
    runReq(0, 32'h20, 32'h0, 2'b01, 0, 32'hFFFF8001, 0, "load_half_s");
    runReq(0, 32'h20, 32'h0, 2'b01, 1, 32'h00008001, 0, "load_half_u");
    runReq(0, 32'h22, 32'h0, 2'b01, 0, 32'h00001234, 0, "load_half_hi");
  endtask

  task automatic test_byte();
    runReq(1, 32'h30, 32'h0, 2'b10, 0, 32'h0, 0, "clear_w30");
    runReq(1, 32'h31, 32'hFFFFFFAB, 2'b00, 0, 32'h0, 0, "store_byte");
    runReq(0, 32'h30, 32'h0, 2'b10, 0, 32'h0000AB00, 0, "word_after_byte");
    runReq(0, 32'h31, 32'h0, 2'b00, 0, 32'hFFFFFFAB, 0, "load_byte_s");
    runReq(0, 32'h31, 32'h0, 2'b00, 1, 32'h000000AB, 0, "load_byte_u");
    runReq(1, 32'h32, 32'hCDEF5566, 2'b01, 0, 32'h0, 0, "store_half_hi");
    runReq(0, 32'h30, 32'h0, 2'b10, 0, 32'h5566AB00, 0, "word_after_half");
    runReq(0, 32'h33, 32'h0, 2'b00, 1, 32'h00000055, 0, "load_byte3_u");
  endtask

  task automatic test_errors();
    runReq(0, 32'h13, 32'h0, 2'b10, 0, 32'h0, 1, "misaligned_word");
    runReq(1, 32'h21, 32'hFFFF, 2'b01, 0, 32'h0, 1, "misaligned_half");
    runReq(0, 32'h20, 32'h0, 2'b10, 0, 32'h12348001, 0, "w20_unchanged");
    runReq(0, 32'h20, 32'h0, 2'b11, 0, 32'h0, 1, "reserved_size");
    runReq(1, 32'h0, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, "store_w0");
    runReq(1, 32'h400, 32'h99999999, 2'b10, 0, 32'h0, 1, "store_oob");
    runReq(0, 32'h400, 32'h0, 2'b10, 0, 32'h0, 1, "load_oob");
    runReq(1, 32'h401, 32'h77, 2'b00, 0, 32'h0, 1, "store_byte_oob");
    runReq(0, 32'h0, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, "w0_unchanged");
  endtask

  task automatic test_backpressure();
    bit got;
    logic [32:0] exp;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    req_size = 2'b10; req_unsigned = 1'b0;
    expQ.push_back({1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (resp_valid) got = 1;
    end
    exp = expQ.pop_front();
    nChecks++;
    if (!got) begin
      nFail++;
      $display("FAIL bp_response: resp_valid never rose, required 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      nChecks++;
      if (resp_valid !== 1'b1 || {resp_error, resp_rdata} !== exp || req_ready !== 1'b0) begin
        nFail++;
        $display("FAIL bp_hold%0d: got valid=%0b err=%0b rdata=%h ready=%0b, required 1 %0b %h 0",
                 i, resp_valid, resp_error, resp_rdata, req_ready, exp[32], exp[31:0]);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    nChecks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      nFail++;
      $display("FAIL bp_release: got valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    runReq(1, 32'h40, 32'h11111111, 2'b10, 0, 32'h0, 0, "store_w40");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h22222222; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      nFail++;
      $display("FAIL reset_mid: got ready=%0b valid=%0b rdata=%h err=%0b, required 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_error);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    nChecks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      nFail++;
      $display("FAIL reset_mid_idle: got valid=%0b ready=%0b, required 0 1", resp_valid, req_ready);
    end
    runReq(0, 32'h40, 32'h0, 2'b10, 0, 32'h11111111, 0, "w40_retained");
  endtask

  // Zero-wait-state instance: response two cycles after acceptance.
  task automatic zReq(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] expData, input string name);
    int lat;
    bit got;
    logic [32:0] exp;
    @(negedge clk);
    zValid = 1'b1; zWrite = wr; zAddr = addr; zWdata = wd; zSize = 2'b10; zUns = 1'b0;
    expQ.push_back({1'b0, expData});
    @(posedge clk); #1;
    zValid = 1'b0; zAddr = $urandom; zWdata = $urandom;
    got = 0; lat = 0;
    while (!got && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (zRespValid) got = 1;
    end
    exp = expQ.pop_front();
    nChecks++;
    if (!got || lat != 2) begin
      nFail++;
      $display("FAIL %s latency: got %0d cycles (valid=%0b), required 2", name, lat, zRespValid);
    end
    nChecks++;
    if ({zRespErr, zRdata} !== exp) begin
      nFail++;
      $display("FAIL %s data: got err=%0b rdata=%h, required err=%0b rdata=%h",
               name, zRespErr, zRdata, exp[32], exp[31:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wait0();
    zReq(1, 32'h8, 32'h13579BDF, 32'h0, "w0_store");
    zReq(0, 32'h8, 32'h0, 32'h13579BDF, "w0_load");
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b10; req_unsigned = 1'b0; resp_ready = 1'b1;
    zValid = 1'b0; zWrite = 1'b0; zAddr = '0; zWdata = '0;
    zSize = 2'b10; zUns = 1'b0; zRespReady = 1'b1;
    repeat (3) @(posedge clk); #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_word();
    test_half();
    test_byte();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_wait0();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
